// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, defaults and bit-period derivation
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT     = 115200;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver; expects an already synchronised rx line
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    rx_state_t        state;
    rx_state_t        state_next;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic tick_half;
    logic tick_full;
    logic cnt_clr;
    logic sample_data;
    logic sample_stop;

    assign tick_half = (cnt == CNT_W'(HALF_BIT - 1));
    assign tick_full = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign data      = shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx) state_next = RX_START;
            RX_START: if (tick_half) state_next = rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_full && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (tick_full) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // The counter restarts at every sample point so later samples land mid-bit.
    always_comb begin
        cnt_clr     = 1'b0;
        sample_data = 1'b0;
        sample_stop = 1'b0;
        case (state)
            RX_IDLE:  cnt_clr = 1'b1;
            RX_START: cnt_clr = tick_half;
            RX_DATA: begin
                cnt_clr     = tick_full;
                sample_data = tick_full;
            end
            RX_STOP: begin
                cnt_clr     = tick_full;
                sample_stop = tick_full;
            end
            default:  cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_prev   <= rx;
            cnt       <= cnt_clr ? '0 : cnt + CNT_W'(1);
            valid     <= sample_stop & rx;
            frame_err <= sample_stop & ~rx;
            if (state == RX_IDLE) begin
                bit_idx <= 3'd0;
            end else if (sample_data) begin
                shift[bit_idx] <= rx;
                bit_idx        <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/top_level.sv
// rtl/top_level.sv - UART byte monitor: input synchronisers, 2-byte LED buffer, sticky flags
module top_level
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int BAUD     = BAUD_DEFAULT
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic        GPIO_3,
    input  logic        GPIO_5,
    output logic [17:0] LEDR
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    logic       clk;
    logic       rst_n;
    logic       rx_s1, rx_s2;
    logic       clr_s1, clr_s2;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       unused_keys;

    assign clk         = CLOCK_50;
    assign rst_n       = KEY[0];
    assign unused_keys = ^KEY[3:1];

    // Both lines idle high, so synchronisers reset high to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            clr_s1 <= 1'b1;
            clr_s2 <= 1'b1;
        end else begin
            rx_s1  <= GPIO_3;
            rx_s2  <= rx_s1;
            clr_s1 <= GPIO_5;
            clr_s2 <= clr_s1;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx_s2),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LEDR <= 18'h0;
        end else if (!clr_s2) begin
            LEDR <= 18'h0;
        end else begin
            if (rx_valid) begin
                LEDR[15:8] <= LEDR[7:0];
                LEDR[7:0]  <= rx_data;
                LEDR[16]   <= 1'b1;
            end
            if (rx_frame_err) begin
                LEDR[17] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_top_level.sv
// tb/tb_top_level.sv - scoreboard bench for top_level UART byte monitor
module tb_top_level;

    localparam int CPB = 434;

    logic        CLOCK_50;
    logic [3:0]  KEY;
    logic        GPIO_3;
    logic        GPIO_5;
    logic [17:0] LEDR;

    int          checks;
    int          errors;
    logic [17:0] exp_q[$];
    logic [17:0] prev_ledr;
    logic        mon_en;

    top_level dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .GPIO_3   (GPIO_3),
        .GPIO_5   (GPIO_5),
        .LEDR     (LEDR)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Every LEDR change must match the next expected value in order.
    always @(negedge CLOCK_50) begin
        if (mon_en && LEDR !== prev_ledr) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_change: LEDR got %05h, no change expected (was %05h)", LEDR, prev_ledr);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (LEDR !== e) begin
                    errors = errors + 1;
                    $display("FAIL ledr_update: LEDR got %05h, expected %05h", LEDR, e);
                end
            end
            prev_ledr = LEDR;
        end
    end

    task automatic wait_bit();
        repeat (CPB) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_level);
        GPIO_3 = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            GPIO_3 = b[i];
            wait_bit();
        end
        GPIO_3 = stop_level;
        wait_bit();
        GPIO_3 = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2 * CPB) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: %0d expected updates still pending, LEDR got %05h", name, exp_q.size(), LEDR);
            exp_q.delete();
        end
    endtask

    task automatic check_ledr(input string name, input logic [17:0] e);
        checks = checks + 1;
        if (LEDR !== e) begin
            errors = errors + 1;
            $display("FAIL %s: LEDR got %05h, expected %05h", name, LEDR, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        prev_ledr = 18'h0;
        KEY    = 4'b1110;
        GPIO_3 = 1'b1;
        GPIO_5 = 1'b1;
        wait_bit();
        KEY = 4'b1111;
        repeat (5) @(negedge CLOCK_50);
        check_ledr("reset_state", 18'h00000);
        prev_ledr = LEDR;
        mon_en = 1'b1;

        exp_q.push_back(18'h100A5);
        send_byte(8'hA5, 1'b1);
        exp_q.push_back(18'h1A5BC);
        send_byte(8'hBC, 1'b1);
        wait_drain("bytes_a5_bc");
        check_ledr("after_bc", 18'h1A5BC);

        exp_q.push_back(18'h3A5BC);
        send_byte(8'h55, 1'b0);
        wait_bit();
        wait_drain("framing_err");
        check_ledr("after_frame_err", 18'h3A5BC);

        GPIO_3 = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        GPIO_3 = 1'b1;
        wait_bit();
        wait_bit();
        check_ledr("after_glitch", 18'h3A5BC);

        exp_q.push_back(18'h3BC12);
        send_byte(8'h12, 1'b1);
        wait_drain("byte_12");
        check_ledr("after_12", 18'h3BC12);

        exp_q.push_back(18'h00000);
        GPIO_5 = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        GPIO_5 = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        wait_drain("clear");
        check_ledr("after_clear", 18'h00000);

        GPIO_5 = 1'b0;
        send_byte(8'h77, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        GPIO_5 = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        check_ledr("clear_beats_valid", 18'h00000);

        exp_q.push_back(18'h10099);
        send_byte(8'h99, 1'b1);
        wait_drain("byte_99");

        GPIO_3 = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            GPIO_3 = (i % 2 == 0) ? 1'b1 : 1'b0;
            wait_bit();
        end
        exp_q.push_back(18'h00000);
        KEY = 4'b1110;
        GPIO_3 = 1'b1;
        wait_bit();
        KEY = 4'b1111;
        repeat (5) @(negedge CLOCK_50);
        wait_drain("mid_frame_reset");
        check_ledr("after_mid_reset", 18'h00000);

        exp_q.push_back(18'h1003C);
        send_byte(8'h3C, 1'b1);
        wait_drain("byte_3c");
        check_ledr("after_3c", 18'h1003C);

        repeat (10) @(negedge CLOCK_50);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_empty: %0d pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD = 434 (8680 ns per bit).
REQ-003 CLOCK_50  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 KEY  input  4  KEY[0] is the reset, asynchronous and active-low; KEY[3:1] unused.
REQ-005 GPIO_3  input  1  UART RX serial line, idle high, 8N1, LSB first.
REQ-006 GPIO_5  input  1  active-low buffer clear request, idle high.
REQ-007 LEDR  output  18  [7:0] newest byte, [15:8] previous byte, [16] byte-received flag, [17] framing-error flag.

Function
REQ-008 GPIO_3 and GPIO_5 SHALL each pass through a 2-flop synchroniser, reset to 1, before any use.
REQ-009 RX FSM states SHALL be IDLE, START, DATA, STOP; IDLE is entered on reset.
REQ-010 IDLE -> START on a synchronised high-to-low transition of RX; baud counter cleared.
REQ-011 START SHALL sample RX at CLKS_PER_BIT/2 (217) clocks: low -> DATA with counter cleared; high -> IDLE (glitch rejected, no flag change).
REQ-012 DATA SHALL sample RX every CLKS_PER_BIT clocks, 8 samples, shifting LSB first into bit index 0..7; after the 8th sample -> STOP.
REQ-013 STOP SHALL sample RX CLKS_PER_BIT clocks after the 8th data sample; high -> byte valid; low -> framing error, byte discarded.
REQ-014 After STOP sampling the FSM SHALL return to IDLE in the same cycle and accept a new start edge immediately (no wait for full stop-bit end).
REQ-015 On a valid byte, a one-cycle rx_valid pulse SHALL shift the buffer: LEDR[15:8] <= LEDR[7:0], LEDR[7:0] <= new byte, LEDR[16] <= 1, all in the cycle after the stop sample.
REQ-016 On a framing error LEDR[17] SHALL be set and the buffer and LEDR[16] left unchanged.
REQ-017 LEDR[16] and LEDR[17] SHALL be sticky until reset or clear.
REQ-018 Synchronised GPIO_5 low SHALL clear LEDR[17:0] to 0 on every clock it is held low; the RX FSM keeps running.
REQ-019 Clear and rx_valid in the same cycle: clear SHALL win (buffer and flags stay 0).
REQ-020 LEDR SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-021 KEY[0] low SHALL asynchronously force: FSM to IDLE, baud counter and bit index to 0, shift register to 0, synchronisers to 1, LEDR[17:0] to 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release the next falling edge starts a fresh frame.

Structure
REQ-023 A package uart_pkg SHALL hold the RX state enum type, CLK_FREQ/BAUD defaults and the CLKS_PER_BIT derivation.
REQ-024 The serial receiver SHALL be one sub-module uart_rx (clk, rst_n, rx, data[7:0], valid, frame_err); top_level holds synchronisers, 2-byte buffer, flags and clear logic.

Verification
REQ-025 KEY[0] low 1 bit time, then high, RX idle -> LEDR = 18'h0.
REQ-026 Send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop high) -> LEDR[7:0]=8'hA5, LEDR[15:8]=8'h00, LEDR[16]=1, LEDR[17]=0.
REQ-027 Then send 0xBC back-to-back (bits 0,0,1,1,1,1,0,1, line held high after) -> LEDR[7:0]=8'hBC, LEDR[15:8]=8'hA5, LEDR[16]=1.
REQ-028 Send 0x55 with stop bit low -> LEDR[17]=1, LEDR[15:0] unchanged.
REQ-029 RX low pulse of 100 ns while idle -> no byte stored, no flag change, FSM back in IDLE.
REQ-030 GPIO_5 low for 10 clocks after REQ-027 -> LEDR = 18'h0; KEY[0] low mid-frame -> LEDR = 0 and next full frame of 0x3C received correctly.
